// File: rtl/imem_boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_pkg
//   Shared definitions for the instruction-memory boot loader: FSM state
//   codes, boot constants and a byte-lane insert helper.
// ---------------------------------------------------------------------------
package imem_boot_loader_pkg;

    // State codes. The FSM register is a plain logic vector compared against
    // these constants so the encoding stays fixed for downstream tools.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_FLUSH   = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_RUN     = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;
    localparam logic [2:0] ST_CKSUM   = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        LOAD    = ST_LOAD,
        FLUSH   = ST_FLUSH,
        RELEASE = ST_RELEASE,
        RUN     = ST_RUN,
        ERR     = ST_ERR,
        CKSUM   = ST_CKSUM
    } boot_state_t;

    // The core starts fetching here once released; the image is loaded
    // from word 0 so the two line up.
    localparam logic [31:0] BOOT_RESET_PC = 32'h0000_0000;

    localparam int BYTE_LANES = 4;

    // Return w with byte b placed in lane l (lane 0 = bits 7:0).
    function automatic logic [31:0] put_lane(input logic [31:0] w,
                                             input logic [1:0]  l,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        case (l)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// imem_byte_packer
//   Packs accepted stream bytes into little-endian 32-bit words.
//   Ports:
//     clk, reset      - clock, synchronous active-low reset
//     clear           - synchronous restart (lane 0, empty word)
//     byte_en         - a byte is accepted this cycle
//     byte_data       - the accepted byte
//     byte_last       - accepted byte closes the word early (zero pad)
//     word_valid      - combinational pulse: this byte completes a word
//     word_data       - the completed word (valid with word_valid)
// ---------------------------------------------------------------------------
module imem_byte_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        word_valid,
    output logic [31:0] word_data
);

    localparam logic [1:0] LAST_LANE = 2'(BYTE_LANES - 1);

    logic [1:0]  lane_q;
    logic [31:0] asm_q;

    // The assembly register is cleared after every word, so lanes that a
    // short final word never reaches are already zero.
    assign word_data  = put_lane(asm_q, lane_q, byte_data);
    assign word_valid = byte_en & ((lane_q == LAST_LANE) | byte_last);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            lane_q <= 2'd0;
            asm_q  <= 32'h0;
        end else if (byte_en) begin
            if (word_valid) begin
                lane_q <= 2'd0;
                asm_q  <= 32'h0;
            end else begin
                lane_q <= lane_q + 2'd1;
                asm_q  <= word_data;
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//   Boot stage for the single-cycle RISC-V core. Accepts a byte stream,
//   writes little-endian words into instruction memory from word 0, and
//   holds the core in reset until the image is in place.
//
//   Build option: IMEM_BOOT_CHECKSUM_EN adds a trailing 4-byte checksum
//   (mod-2^32 sum of written words) and the cksum_err output.
//
//   Ports:
//     clk, reset            - clock, synchronous active-low reset
//     load_start            - request a (re)load (IDLE, RUN, ERR only)
//     s_valid/s_data/s_last - byte stream in; s_ready - byte accepted
//     imem_we/addr/wdata    - instruction-memory write port
//     core_reset            - active-low core reset (0 holds the core)
//     busy, done            - loading / program running
//     word_count            - words written in the current load
//     err_overflow          - sticky: image larger than MAX_WORDS
//     cksum_err             - sticky checksum mismatch (option only)
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | after reset, core held, waiting for load_start
//   LOAD    | accepting image bytes, writing completed words
//   FLUSH   | one cycle: final word write on the bus
//   CKSUM   | accepting the 4 checksum bytes (option only)
//   RELEASE | one cycle: core still held while the last write settles
//   RUN     | core released, done=1; load_start reloads
//   ERR     | overflow or checksum error, core held; load_start reloads
// ---------------------------------------------------------------------------
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
`ifdef IMEM_BOOT_CHECKSUM_EN
    output logic              cksum_err,
`endif
    output logic              err_overflow
);

    localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(MAX_WORDS);

    logic [2:0]  state;
    logic        load_go;
    logic        pk_en;
    logic        pk_last;
    logic        pk_valid;
    logic [31:0] pk_word;

    assign load_go = load_start & ((state == ST_IDLE) | (state == ST_RUN) |
                                   (state == ST_ERR));
    // s_ready is only high in LOAD/CKSUM, so the handshake alone gates
    // the packer; s_last only means anything during the image itself.
    assign pk_en   = s_valid & s_ready;
    assign pk_last = s_last & (state == ST_LOAD);

    imem_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (load_go),
        .byte_en    (pk_en),
        .byte_data  (s_data),
        .byte_last  (pk_last),
        .word_valid (pk_valid),
        .word_data  (pk_word)
    );

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [31:0] sum_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            s_ready      <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'h0;
            core_reset   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            word_count   <= '0;
            err_overflow <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            cksum_err    <= 1'b0;
            sum_q        <= 32'h0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_RUN, ST_ERR: begin
                    if (load_go) begin
                        state        <= ST_LOAD;
                        s_ready      <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        core_reset   <= 1'b0;
                        word_count   <= '0;
                        err_overflow <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        cksum_err    <= 1'b0;
                        sum_q        <= 32'h0;
`endif
                    end
                end

                ST_LOAD: begin
                    // An accepted s_last always completes a word, so every
                    // exit from LOAD goes through this branch.
                    if (pk_valid) begin
                        if (word_count == CAP) begin
                            err_overflow <= 1'b1;
                            state        <= ST_ERR;
                            s_ready      <= 1'b0;
                            busy         <= 1'b0;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_count[ADDR_W-1:0];
                            imem_wdata <= pk_word;
                            word_count <= word_count + 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                            sum_q      <= sum_q + pk_word;
`endif
                            if (pk_last) begin
                                state   <= ST_FLUSH;
                                s_ready <= 1'b0;
                            end
                        end
                    end
                end

                ST_FLUSH: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                    state   <= ST_CKSUM;
                    s_ready <= 1'b1;
`else
                    state <= ST_RELEASE;
                    busy  <= 1'b0;
`endif
                end

`ifdef IMEM_BOOT_CHECKSUM_EN
                ST_CKSUM: begin
                    // The packer reassembles the 4 checksum bytes; the word
                    // is compared, never written.
                    if (pk_valid) begin
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        if (pk_word == sum_q) begin
                            state <= ST_RELEASE;
                        end else begin
                            state     <= ST_ERR;
                            cksum_err <= 1'b1;
                        end
                    end
                end
`endif

                ST_RELEASE: begin
                    state      <= ST_RUN;
                    core_reset <= 1'b1;
                    done       <= 1'b1;
                end

                default: begin
                    state   <= ST_IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream boot stage for the single-cycle RISC-V core.
- Receives a byte stream over a valid/ready handshake and packs it into little-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses from 0.
- Holds the core in reset until the program is loaded, then releases it so execution starts at PC 0.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- MAX_WORDS, 256, capacity in words; must be ≤ 2**ADDR_W.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-low reset.
- load_start, input, 1, request a (re)load; sampled in IDLE, RUN, ERR.
- s_valid, input, 1, stream byte valid.
- s_data, input, 8, stream byte.
- s_last, input, 1, final byte of image; qualified by s_valid.
- s_ready, output, 1, loader accepts a byte this cycle.
- imem_we, output, 1, instruction-memory write strobe (one-cycle pulse).
- imem_addr, output, ADDR_W, word address.
- imem_wdata, output, 32, word data.
- core_reset, output, 1, active-low reset to the core; 0 holds the core.
- busy, output, 1, high in LOAD and FLUSH.
- done, output, 1, high in RUN.
- word_count, output, ADDR_W+1, words written in the current load.
- err_overflow, output, 1, sticky image-too-large flag.

Behaviour:
- All state and outputs are registered. reset==0 at a clk edge gives:
  - state IDLE; s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0;
  - core_reset=0, busy=0, done=0, word_count=0, err_overflow=0;
  - byte lane index cleared.
- Reset asserted mid-load aborts immediately. Partial words are discarded and the core stays held.
- States are IDLE, LOAD, FLUSH, RELEASE, RUN, ERR.
- IDLE: core_reset=0. load_start=1 → LOAD, with word_count=0 and lane=0.
- LOAD: s_ready=1. On each handshake (s_valid & s_ready), s_data goes into byte lane[lane] (lane 0 = bits 7:0), then lane++.
  - When lane 3 is accepted, or s_last is accepted at any lane: the next cycle gives imem_we=1, imem_addr=word_count[ADDR_W-1:0], imem_wdata=assembled word, then word_count++.
  - Unfilled lanes are zero-padded. Lane and assembly register clear after the write.
  - Write latency is one cycle after the completing handshake.
  - Back-to-back bytes are accepted every cycle with no bubbles.
- s_last accepted → FLUSH. s_ready=0 from the next cycle.
- If s_last is accepted with lane==0 and no bytes are pending (the byte itself starts the word), it is still written as a padded word.
- FLUSH: lasts one cycle, covering the final write, then → RELEASE.
- Overflow: a word completes while word_count==MAX_WORDS.
  - No write occurs; err_overflow is set; go to ERR.
- ERR: core_reset=0, s_ready=0. load_start=1 → LOAD. err_overflow clears only on reset or on entry to LOAD.
- RELEASE: lasts one cycle with core_reset still 0 so the last write settles. Then → RUN.
- RUN: core_reset=1, done=1. load_start=1 → LOAD; core_reset drops to 0 on the same edge.
- load_start is ignored in LOAD, FLUSH and RELEASE.
- s_valid with s_ready=0 is not consumed. The source holds the byte.
- Empty image (s_last on first byte) yields one padded word, word_count=1.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- When defined:
  - After s_last, the loader stays in a CKSUM state (s_ready=1) and accepts 4 more bytes, a little-endian 32-bit checksum.
  - The checksum is the mod-2^32 sum of all written words, including padded ones.
  - Match → RELEASE. Mismatch → ERR, with extra output cksum_err=1 (sticky, clears on reset or LOAD entry).
  - Checksum bytes are never written to imem.
- When undefined: no CKSUM state, no cksum_err port, and FLUSH → RELEASE directly.

Decomposition:
- Shared package (def.h):
  - state enum boot_state_t {IDLE, LOAD, FLUSH, RELEASE, RUN, ERR, CKSUM};
  - BOOT_RESET_PC = 0;
  - byte-lane count constant = 4.
- One natural sub-module: imem_byte_packer, the lane counter plus assembly register with a word_valid pulse and zero-pad on last. The FSM and counters stay in the top.

Test Plan:
- Reset, then load_start pulse and 8 bytes 13 05 50 00 93 05 A0 00 (s_last on the 8th) → writes addr0=0x00500513 and addr1=0x00A00593; word_count=2; core_reset rises 2 cycles after the addr1 write; done=1.
- 6 bytes with s_last on the 6th → addr1 written as 0x0000BBAA (zero-padded); word_count=2.
- s_valid toggled every other cycle → words identical to the unstalled case; no byte dropped or duplicated; imem_we pulses exactly once per word.
- MAX_WORDS=2 with a 12-byte image → 2 writes, no third imem_we; err_overflow=1; core_reset stays 0; new load_start clears the flag.
- reset=0 after 5 accepted bytes → all outputs back to reset values; following load starts at addr0.
- With IMEM_BOOT_CHECKSUM_EN: image 0x00000001 plus checksum bytes 01 00 00 00 → RUN. Same image with checksum 02 00 00 00 → ERR, cksum_err=1, core_reset=0.
